// File: rtl/id_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the ID/EX pipeline register of the dual-issue core:
//   - ALU_OP_BITS            : width of the decoded ALU operation field
//   - NUM_REGISTERS_LOG2_DEF : default register-index width
//   - STALL_COUNT_MAX        : saturation value of the load-use bubble counter
//   - BUBBLE_FILL            : fill value for every lane field in a bubble
//   - upd_e                  : what the ID/EX register does on a clock edge
// -----------------------------------------------------------------------------
package id_ex_stage_pkg;

    localparam int          ALU_OP_BITS            = 4;
    localparam int          NUM_REGISTERS_LOG2_DEF = 5;
    localparam logic [31:0] STALL_COUNT_MAX        = 32'hFFFF_FFFF;

    // A bubble zeroes every field, so valid/reg_write/mem_read/mem_write are 0
    // and the don't-care payload fields stay deterministic.
    localparam logic        BUBBLE_FILL            = 1'b0;

    // Edge action of the ID/EX register, listed in priority order.
    typedef enum logic [1:0] {
        UPD_FLUSH = 2'd0,   // squash: load a bubble
        UPD_HOLD  = 2'd1,   // downstream freeze: keep contents
        UPD_STALL = 2'd2,   // load-use hazard: load a bubble
        UPD_LOAD  = 2'd3    // normal capture of the decode pair
    } upd_e;

endpackage

// File: rtl/id_ex_lane_reg.sv
// -----------------------------------------------------------------------------
// id_ex_lane_reg
// One lane of the ID/EX register. Priority: bubble > hold > load.
// Ports:
//   clk, reset               : clock, async active-high reset
//   load, hold, bubble       : edge controls from the stage top
//   id_*                     : decoded fields of this lane
//   ex_*                     : registered copies of the id_* fields
// -----------------------------------------------------------------------------
module id_ex_lane_reg
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int NUM_REGISTERS_LOG2 = NUM_REGISTERS_LOG2_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          hold,
    input  logic                          bubble,
    input  logic                          id_valid,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rs,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rt,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_rd,
    input  logic [DATA_W-1:0]             id_rs_data,
    input  logic [DATA_W-1:0]             id_rt_data,
    input  logic [DATA_W-1:0]             id_imm,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          id_mem_write,
    input  logic                          id_mem_to_reg,
    input  logic [ALU_OP_BITS-1:0]        id_alu_op,
    output logic                          ex_valid,
    output logic [NUM_REGISTERS_LOG2-1:0] ex_rs,
    output logic [NUM_REGISTERS_LOG2-1:0] ex_rt,
    output logic [NUM_REGISTERS_LOG2-1:0] ex_rd,
    output logic [DATA_W-1:0]             ex_rs_data,
    output logic [DATA_W-1:0]             ex_rt_data,
    output logic [DATA_W-1:0]             ex_imm,
    output logic                          ex_reg_write,
    output logic                          ex_mem_read,
    output logic                          ex_mem_write,
    output logic                          ex_mem_to_reg,
    output logic [ALU_OP_BITS-1:0]        ex_alu_op
);

    // All lane fields travel as one packed word so bubble/hold/load act uniformly.
    localparam int LANE_W = 1 + 3 * NUM_REGISTERS_LOG2 + 3 * DATA_W + 4 + ALU_OP_BITS;

    logic [LANE_W-1:0] id_word_s;
    logic [LANE_W-1:0] lane_r;

    assign id_word_s = {id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
                        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_op};

    assign {ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
            ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_op} = lane_r;

    // Lane register: async clear, then bubble, hold, or capture of the decode fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_r <= {LANE_W{1'b0}};
        end else if (bubble) begin
            lane_r <= {LANE_W{BUBBLE_FILL}};
        end else if (hold) begin
            lane_r <= lane_r;
        end else if (load) begin
            lane_r <= id_word_s;
        end else begin
            lane_r <= lane_r;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Dual-lane ID/EX pipeline register with load-use hazard detection.
// Ports:
//   clk, reset          : clock, async active-high reset
//   idL_* (L = 0,1)     : decoded fields of each lane
//   id_first            : lane 1 is the younger instruction of the pair
//   flush               : squash the decode pair (loads a bubble)
//   hold                : downstream freeze (keeps all registers)
//   exL_* (L = 0,1)     : registered lane fields (one-cycle latency)
//   ex_first            : registered id_first
//   load_use_stall      : combinational, asks fetch/decode to hold IF/ID
//   stall_count         : saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W             = 32,
    parameter int NUM_REGISTERS_LOG2 = NUM_REGISTERS_LOG2_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id0_valid,
    input  logic [NUM_REGISTERS_LOG2-1:0] id0_rs,
    input  logic [NUM_REGISTERS_LOG2-1:0] id0_rt,
    input  logic [NUM_REGISTERS_LOG2-1:0] id0_rd,
    input  logic [DATA_W-1:0]             id0_rs_data,
    input  logic [DATA_W-1:0]             id0_rt_data,
    input  logic [DATA_W-1:0]             id0_imm,
    input  logic                          id0_reg_write,
    input  logic                          id0_mem_read,
    input  logic                          id0_mem_write,
    input  logic                          id0_mem_to_reg,
    input  logic [ALU_OP_BITS-1:0]        id0_alu_op,
    input  logic                          id1_valid,
    input  logic [NUM_REGISTERS_LOG2-1:0] id1_rs,
    input  logic [NUM_REGISTERS_LOG2-1:0] id1_rt,
    input  logic [NUM_REGISTERS_LOG2-1:0] id1_rd,
    input  logic [DATA_W-1:0]             id1_rs_data,
    input  logic [DATA_W-1:0]             id1_rt_data,
    input  logic [DATA_W-1:0]             id1_imm,
    input  logic                          id1_reg_write,
    input  logic                          id1_mem_read,
    input  logic                          id1_mem_write,
    input  logic                          id1_mem_to_reg,
    input  logic [ALU_OP_BITS-1:0]        id1_alu_op,
    input  logic                          id_first,
    input  logic                          flush,
    input  logic                          hold,
    output logic                          ex0_valid,
    output logic [NUM_REGISTERS_LOG2-1:0] ex0_rs,
    output logic [NUM_REGISTERS_LOG2-1:0] ex0_rt,
    output logic [NUM_REGISTERS_LOG2-1:0] ex0_rd,
    output logic [DATA_W-1:0]             ex0_rs_data,
    output logic [DATA_W-1:0]             ex0_rt_data,
    output logic [DATA_W-1:0]             ex0_imm,
    output logic                          ex0_reg_write,
    output logic                          ex0_mem_read,
    output logic                          ex0_mem_write,
    output logic                          ex0_mem_to_reg,
    output logic [ALU_OP_BITS-1:0]        ex0_alu_op,
    output logic                          ex1_valid,
    output logic [NUM_REGISTERS_LOG2-1:0] ex1_rs,
    output logic [NUM_REGISTERS_LOG2-1:0] ex1_rt,
    output logic [NUM_REGISTERS_LOG2-1:0] ex1_rd,
    output logic [DATA_W-1:0]             ex1_rs_data,
    output logic [DATA_W-1:0]             ex1_rt_data,
    output logic [DATA_W-1:0]             ex1_imm,
    output logic                          ex1_reg_write,
    output logic                          ex1_mem_read,
    output logic                          ex1_mem_write,
    output logic                          ex1_mem_to_reg,
    output logic [ALU_OP_BITS-1:0]        ex1_alu_op,
    output logic                          ex_first,
    output logic                          load_use_stall,
    output logic [31:0]                   stall_count
);

    localparam logic [NUM_REGISTERS_LOG2-1:0] REG_ZERO = {NUM_REGISTERS_LOG2{1'b0}};

    upd_e        upd_s;
    logic        hazard_s;
    logic        lane_load_s;
    logic        lane_hold_s;
    logic        lane_bubble_s;
    logic        ex_first_r;
    logic [31:0] stall_count_r;

    // True when a load sitting in EX writes a register read by a valid decode slot.
    // Register 0 is hard-wired and never creates a dependency.
    function automatic logic load_hit(
        input logic                          ld_valid,
        input logic                          ld_mem_read,
        input logic [NUM_REGISTERS_LOG2-1:0] ld_rd,
        input logic                          use_valid,
        input logic [NUM_REGISTERS_LOG2-1:0] use_rs,
        input logic [NUM_REGISTERS_LOG2-1:0] use_rt
    );
        load_hit = ld_valid && ld_mem_read && (ld_rd != REG_ZERO) && use_valid &&
                   ((ld_rd == use_rs) || (ld_rd == use_rt));
    endfunction

    // Raw hazard across every EX-lane / ID-lane pairing; either one bubbles both lanes.
    always_comb begin
        hazard_s = 1'b0;
        hazard_s = load_hit(ex0_valid, ex0_mem_read, ex0_rd, id0_valid, id0_rs, id0_rt) ||
                   load_hit(ex0_valid, ex0_mem_read, ex0_rd, id1_valid, id1_rs, id1_rt) ||
                   load_hit(ex1_valid, ex1_mem_read, ex1_rd, id0_valid, id0_rs, id0_rt) ||
                   load_hit(ex1_valid, ex1_mem_read, ex1_rd, id1_valid, id1_rs, id1_rt);
    end

    // Edge action selection; flush and hold outrank the hazard, which gates the stall off.
    always_comb begin
        upd_s = UPD_LOAD;
        if (flush) begin
            upd_s = UPD_FLUSH;
        end else if (hold) begin
            upd_s = UPD_HOLD;
        end else if (hazard_s) begin
            upd_s = UPD_STALL;
        end else begin
            upd_s = UPD_LOAD;
        end
    end

    assign load_use_stall = (upd_s == UPD_STALL);
    assign lane_bubble_s  = (upd_s == UPD_FLUSH) || (upd_s == UPD_STALL);
    assign lane_hold_s    = (upd_s == UPD_HOLD);
    assign lane_load_s    = (upd_s == UPD_LOAD);

    id_ex_lane_reg #(
        .DATA_W             (DATA_W),
        .NUM_REGISTERS_LOG2 (NUM_REGISTERS_LOG2)
    ) u_lane0 (
        .clk           (clk),
        .reset         (reset),
        .load          (lane_load_s),
        .hold          (lane_hold_s),
        .bubble        (lane_bubble_s),
        .id_valid      (id0_valid),
        .id_rs         (id0_rs),
        .id_rt         (id0_rt),
        .id_rd         (id0_rd),
        .id_rs_data    (id0_rs_data),
        .id_rt_data    (id0_rt_data),
        .id_imm        (id0_imm),
        .id_reg_write  (id0_reg_write),
        .id_mem_read   (id0_mem_read),
        .id_mem_write  (id0_mem_write),
        .id_mem_to_reg (id0_mem_to_reg),
        .id_alu_op     (id0_alu_op),
        .ex_valid      (ex0_valid),
        .ex_rs         (ex0_rs),
        .ex_rt         (ex0_rt),
        .ex_rd         (ex0_rd),
        .ex_rs_data    (ex0_rs_data),
        .ex_rt_data    (ex0_rt_data),
        .ex_imm        (ex0_imm),
        .ex_reg_write  (ex0_reg_write),
        .ex_mem_read   (ex0_mem_read),
        .ex_mem_write  (ex0_mem_write),
        .ex_mem_to_reg (ex0_mem_to_reg),
        .ex_alu_op     (ex0_alu_op)
    );

    id_ex_lane_reg #(
        .DATA_W             (DATA_W),
        .NUM_REGISTERS_LOG2 (NUM_REGISTERS_LOG2)
    ) u_lane1 (
        .clk           (clk),
        .reset         (reset),
        .load          (lane_load_s),
        .hold          (lane_hold_s),
        .bubble        (lane_bubble_s),
        .id_valid      (id1_valid),
        .id_rs         (id1_rs),
        .id_rt         (id1_rt),
        .id_rd         (id1_rd),
        .id_rs_data    (id1_rs_data),
        .id_rt_data    (id1_rt_data),
        .id_imm        (id1_imm),
        .id_reg_write  (id1_reg_write),
        .id_mem_read   (id1_mem_read),
        .id_mem_write  (id1_mem_write),
        .id_mem_to_reg (id1_mem_to_reg),
        .id_alu_op     (id1_alu_op),
        .ex_valid      (ex1_valid),
        .ex_rs         (ex1_rs),
        .ex_rt         (ex1_rt),
        .ex_rd         (ex1_rd),
        .ex_rs_data    (ex1_rs_data),
        .ex_rt_data    (ex1_rt_data),
        .ex_imm        (ex1_imm),
        .ex_reg_write  (ex1_reg_write),
        .ex_mem_read   (ex1_mem_read),
        .ex_mem_write  (ex1_mem_write),
        .ex_mem_to_reg (ex1_mem_to_reg),
        .ex_alu_op     (ex1_alu_op)
    );

    // Lane-order flag follows the same bubble/hold/load action as the lane registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_first_r <= 1'b0;
        end else begin
            case (upd_s)
                UPD_FLUSH: ex_first_r <= 1'b0;
                UPD_STALL: ex_first_r <= 1'b0;
                UPD_HOLD:  ex_first_r <= ex_first_r;
                UPD_LOAD:  ex_first_r <= id_first;
                default:   ex_first_r <= 1'b0;
            endcase
        end
    end

    // Counts only hazard bubbles (not flushes) and sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_r <= 32'd0;
        end else if ((upd_s == UPD_STALL) && (stall_count_r != STALL_COUNT_MAX)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign ex_first    = ex_first_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: capture, load-use bubble, register-0 exemption,
// hold, flush-over-hold and asynchronous reset, with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk;
    logic          reset;
    logic          id0_valid, id1_valid;
    logic [RW-1:0] id0_rs, id0_rt, id0_rd, id1_rs, id1_rt, id1_rd;
    logic [DW-1:0] id0_rs_data, id0_rt_data, id0_imm, id1_rs_data, id1_rt_data, id1_imm;
    logic          id0_reg_write, id0_mem_read, id0_mem_write, id0_mem_to_reg;
    logic          id1_reg_write, id1_mem_read, id1_mem_write, id1_mem_to_reg;
    logic [ALU_OP_BITS-1:0] id0_alu_op, id1_alu_op;
    logic          id_first, flush, hold;
    logic          ex0_valid, ex1_valid;
    logic [RW-1:0] ex0_rs, ex0_rt, ex0_rd, ex1_rs, ex1_rt, ex1_rd;
    logic [DW-1:0] ex0_rs_data, ex0_rt_data, ex0_imm, ex1_rs_data, ex1_rt_data, ex1_imm;
    logic          ex0_reg_write, ex0_mem_read, ex0_mem_write, ex0_mem_to_reg;
    logic          ex1_reg_write, ex1_mem_read, ex1_mem_write, ex1_mem_to_reg;
    logic [ALU_OP_BITS-1:0] ex0_alu_op, ex1_alu_op;
    logic          ex_first, load_use_stall;
    logic [31:0]   stall_count;

    int n_total;
    int n_bad;

    id_ex_stage #(.DATA_W(DW), .NUM_REGISTERS_LOG2(RW)) dut (
        .clk(clk), .reset(reset),
        .id0_valid(id0_valid), .id0_rs(id0_rs), .id0_rt(id0_rt), .id0_rd(id0_rd),
        .id0_rs_data(id0_rs_data), .id0_rt_data(id0_rt_data), .id0_imm(id0_imm),
        .id0_reg_write(id0_reg_write), .id0_mem_read(id0_mem_read),
        .id0_mem_write(id0_mem_write), .id0_mem_to_reg(id0_mem_to_reg), .id0_alu_op(id0_alu_op),
        .id1_valid(id1_valid), .id1_rs(id1_rs), .id1_rt(id1_rt), .id1_rd(id1_rd),
        .id1_rs_data(id1_rs_data), .id1_rt_data(id1_rt_data), .id1_imm(id1_imm),
        .id1_reg_write(id1_reg_write), .id1_mem_read(id1_mem_read),
        .id1_mem_write(id1_mem_write), .id1_mem_to_reg(id1_mem_to_reg), .id1_alu_op(id1_alu_op),
        .id_first(id_first), .flush(flush), .hold(hold),
        .ex0_valid(ex0_valid), .ex0_rs(ex0_rs), .ex0_rt(ex0_rt), .ex0_rd(ex0_rd),
        .ex0_rs_data(ex0_rs_data), .ex0_rt_data(ex0_rt_data), .ex0_imm(ex0_imm),
        .ex0_reg_write(ex0_reg_write), .ex0_mem_read(ex0_mem_read),
        .ex0_mem_write(ex0_mem_write), .ex0_mem_to_reg(ex0_mem_to_reg), .ex0_alu_op(ex0_alu_op),
        .ex1_valid(ex1_valid), .ex1_rs(ex1_rs), .ex1_rt(ex1_rt), .ex1_rd(ex1_rd),
        .ex1_rs_data(ex1_rs_data), .ex1_rt_data(ex1_rt_data), .ex1_imm(ex1_imm),
        .ex1_reg_write(ex1_reg_write), .ex1_mem_read(ex1_mem_read),
        .ex1_mem_write(ex1_mem_write), .ex1_mem_to_reg(ex1_mem_to_reg), .ex1_alu_op(ex1_alu_op),
        .ex_first(ex_first), .load_use_stall(load_use_stall), .stall_count(stall_count)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_ids();
        id0_valid = 1'b0; id0_rs = 5'd0; id0_rt = 5'd0; id0_rd = 5'd0;
        id0_rs_data = 32'd0; id0_rt_data = 32'd0; id0_imm = 32'd0;
        id0_reg_write = 1'b0; id0_mem_read = 1'b0; id0_mem_write = 1'b0;
        id0_mem_to_reg = 1'b0; id0_alu_op = 4'd0;
        id1_valid = 1'b0; id1_rs = 5'd0; id1_rt = 5'd0; id1_rd = 5'd0;
        id1_rs_data = 32'd0; id1_rt_data = 32'd0; id1_imm = 32'd0;
        id1_reg_write = 1'b0; id1_mem_read = 1'b0; id1_mem_write = 1'b0;
        id1_mem_to_reg = 1'b0; id1_alu_op = 4'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset = 1'b0; flush = 1'b0; hold = 1'b0; id_first = 1'b0;
        clear_ids();

        // Reset state
        #2 reset = 1'b1;
        #1;
        check_val("rst_ex0_valid", 32'(ex0_valid), 32'd0);
        check_val("rst_ex_first", 32'(ex_first), 32'd0);
        check_val("rst_stall_count", stall_count, 32'd0);
        check_val("rst_stall", 32'(load_use_stall), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Normal capture
        id0_valid = 1'b1; id0_rd = 5'd3; id0_reg_write = 1'b1; id0_rs = 5'd1; id0_rt = 5'd2;
        id0_rs_data = 32'hDEAD_0001; id0_alu_op = 4'h5;
        id1_valid = 1'b1; id1_rd = 5'd7; id1_imm = 32'h0000_1234; id_first = 1'b1;
        #1 check_val("cap_pre_stall", 32'(load_use_stall), 32'd0);
        tick();
        check_val("cap_ex0_valid", 32'(ex0_valid), 32'd1);
        check_val("cap_ex0_rd", 32'(ex0_rd), 32'd3);
        check_val("cap_ex0_reg_write", 32'(ex0_reg_write), 32'd1);
        check_val("cap_ex0_rs_data", ex0_rs_data, 32'hDEAD_0001);
        check_val("cap_ex0_alu_op", 32'(ex0_alu_op), 32'd5);
        check_val("cap_ex1_rd", 32'(ex1_rd), 32'd7);
        check_val("cap_ex1_imm", ex1_imm, 32'h0000_1234);
        check_val("cap_ex_first", 32'(ex_first), 32'd1);
        check_val("cap_stall", 32'(load_use_stall), 32'd0);

        // Load in lane 0 (rd=5), then lane 1 reads r5
        clear_ids();
        id0_valid = 1'b1; id0_mem_read = 1'b1; id0_rd = 5'd5; id_first = 1'b0;
        id1_valid = 1'b1; id1_rd = 5'd6;
        tick();
        check_val("lu_ex0_mem_read", 32'(ex0_mem_read), 32'd1);
        check_val("lu_ex_first0", 32'(ex_first), 32'd0);
        clear_ids();
        id0_valid = 1'b1; id0_rs = 5'd1; id0_rt = 5'd2;
        id1_valid = 1'b1; id1_rs = 5'd5; id1_rd = 5'd8; id1_reg_write = 1'b1; id_first = 1'b1;
        #1 check_val("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        check_val("lu_bub_ex0_valid", 32'(ex0_valid), 32'd0);
        check_val("lu_bub_ex1_valid", 32'(ex1_valid), 32'd0);
        check_val("lu_bub_ex0_mem_read", 32'(ex0_mem_read), 32'd0);
        check_val("lu_bub_ex1_reg_write", 32'(ex1_reg_write), 32'd0);
        check_val("lu_bub_ex1_rd", 32'(ex1_rd), 32'd0);
        check_val("lu_bub_ex_first", 32'(ex_first), 32'd0);
        check_val("lu_count1", stall_count, 32'd1);
        check_val("lu_stall_clear", 32'(load_use_stall), 32'd0);
        tick();
        check_val("lu_after_ex1_valid", 32'(ex1_valid), 32'd1);
        check_val("lu_after_ex1_rs", 32'(ex1_rs), 32'd5);
        check_val("lu_after_ex_first", 32'(ex_first), 32'd1);
        check_val("lu_after_count", stall_count, 32'd1);

        // Load in lane 1 (rd=9), lane 0 reads r9 through rt
        clear_ids();
        id1_valid = 1'b1; id1_mem_read = 1'b1; id1_rd = 5'd9; id0_valid = 1'b1; id_first = 1'b0;
        tick();
        clear_ids();
        id0_rt = 5'd9;
        #1 check_val("lu1_invalid_use", 32'(load_use_stall), 32'd0);
        id0_valid = 1'b1;
        #1 check_val("lu1_stall", 32'(load_use_stall), 32'd1);
        tick();
        check_val("lu1_bub_ex0_valid", 32'(ex0_valid), 32'd0);
        check_val("lu1_count2", stall_count, 32'd2);

        // Register 0 never causes a hazard
        clear_ids();
        id1_valid = 1'b1; id1_mem_read = 1'b1; id1_rd = 5'd0; id0_valid = 1'b1;
        tick();
        clear_ids();
        id0_valid = 1'b1; id0_rt = 5'd0; id0_rd = 5'd12;
        #1 check_val("r0_stall", 32'(load_use_stall), 32'd0);
        tick();
        check_val("r0_ex0_valid", 32'(ex0_valid), 32'd1);
        check_val("r0_ex0_rd", 32'(ex0_rd), 32'd12);
        check_val("r0_count", stall_count, 32'd2);

        // Hold for three cycles with a pending hazard and changing decode fields
        clear_ids();
        id0_valid = 1'b1; id0_mem_read = 1'b1; id0_rd = 5'd4; id_first = 1'b1;
        tick();
        clear_ids();
        id1_valid = 1'b1; id1_rs = 5'd4; id_first = 1'b0; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id0_valid = 1'b1; id0_rd = 5'(10 + i); id0_imm = 32'(i + 1);
            #1 check_val("hold_stall_pre", 32'(load_use_stall), 32'd0);
            tick();
            check_val("hold_ex0_rd", 32'(ex0_rd), 32'd4);
            check_val("hold_ex0_imm", ex0_imm, 32'd0);
            check_val("hold_ex_first", 32'(ex_first), 32'd1);
            check_val("hold_stall", 32'(load_use_stall), 32'd0);
        end
        hold = 1'b0;
        #1 check_val("unhold_stall", 32'(load_use_stall), 32'd1);

        // Flush wins over hold and does not count as a stall
        flush = 1'b1; hold = 1'b1;
        #1 check_val("flush_stall", 32'(load_use_stall), 32'd0);
        tick();
        check_val("flush_ex0_valid", 32'(ex0_valid), 32'd0);
        check_val("flush_ex0_mem_read", 32'(ex0_mem_read), 32'd0);
        check_val("flush_ex_first", 32'(ex_first), 32'd0);
        check_val("flush_count", stall_count, 32'd2);
        flush = 1'b0; hold = 1'b0;

        // Async reset in the middle of a pending stall
        clear_ids();
        id0_valid = 1'b1; id0_mem_read = 1'b1; id0_rd = 5'd7;
        tick();
        clear_ids();
        id0_valid = 1'b1; id0_rs = 5'd7; id0_rd = 5'd13; id_first = 1'b1;
        #1 check_val("ar_stall_pre", 32'(load_use_stall), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("ar_ex0_valid", 32'(ex0_valid), 32'd0);
        check_val("ar_ex0_rd", 32'(ex0_rd), 32'd0);
        check_val("ar_ex0_mem_read", 32'(ex0_mem_read), 32'd0);
        check_val("ar_count", stall_count, 32'd0);
        check_val("ar_stall", 32'(load_use_stall), 32'd0);
        reset = 1'b0;
        tick();
        check_val("ar_cap_ex0_valid", 32'(ex0_valid), 32'd1);
        check_val("ar_cap_ex0_rd", 32'(ex0_rd), 32'd13);
        check_val("ar_cap_ex_first", 32'(ex_first), 32'd1);
        check_val("ar_cap_count", stall_count, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
